gpu_cmd_ctrl: RTL and testbench
===============================

// Module: gpu_cmd_ctrl
// PURPOSE
//  Register-bank controller on the EPP-side ip_* bus; converts host register traffic into drawing-engine commands.
//  Host loads coordinates and colour, then writes CMD. The controller snapshots the arguments into a one-deep
//  command slot and hands them to the engine over a valid/ready handshake. It stalls the host (ip_do_rdy low)
//  while the slot is full, and reports status and a command count.
// PARAMETERS
//  ADDR_BASE  8'h10  register window base (16-aligned); window = ADDR_BASE..ADDR_BASE+15
//  X_BITS     10     width of x coordinates
//  Y_BITS     9      width of y coordinates
//  STALL_MAX  1023   max stall cycles on CMD write before the command is dropped
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  ip_addr    in   8       register address from EPP bus
//  ip_do      in   8       write data from host
//  ip_wr      in   1       1-cycle write pulse
//  ip_rd      in   1       1-cycle read pulse
//  ip_di      out  8       read data to host
//  ip_do_rdy  out  1       level: transaction complete / controller idle
//  cmd_valid  out  1       command slot full
//  cmd_ready  in   1       engine accepts slot contents this cycle
//  cmd_op     out  4       opcode
//  cmd_x1/cmd_x2 out X_BITS  snapshotted x coords
//  cmd_y1/cmd_y2 out Y_BITS  snapshotted y coords
//  cmd_color  out  8       snapshotted colour
//  eng_busy   in   1       engine executing (status only)
// BEHAVIOUR
//  Reset: ip_di=0, ip_do_rdy=1, cmd_valid=0, all cmd_* and registers 0, err=0, cnt=0, stall counter 0.
//  Register map (offset from ADDR_BASE):
//   0/1 X1 lo/hi; 2/3 Y1 lo/hi; 4/5 X2 lo/hi; 6/7 Y2 lo/hi.
//   Hi bytes keep only the coordinate's upper bits; unused bits read 0.
//   8 COLOR r/w; 9 CMD w (bits[3:0]=op), reads last op; A STATUS r; B CNT r; C SCRATCH r/w; others reserved.
//  STATUS = {5'b0, err, eng_busy, cmd_valid}; reading STATUS clears err on the same edge (value returned pre-clear).
//  Reserved offsets and addresses outside the window: writes ignored, reads return 8'h00, zero wait.
//  ip_wr and ip_rd both high: write wins, read ignored.
//  Timing: on the edge sampling ip_rd=1, ip_di is loaded and ip_do_rdy stays 1.
//   Non-stalled accesses complete with zero wait: ip_do_rdy is already 1 in the next cycle.
//  CMD write, op!=0:
//   - Slot free, or draining this cycle (cmd_valid && cmd_ready):
//     load cmd_* from the live registers, cmd_valid<=1, cnt<=cnt+1 (8-bit, wraps 255->0). No stall.
//   - Slot full and not draining: enter STALL; ip_do_rdy<=0 on that same edge and op is latched.
//  CMD write, op==0 (NOP): no slot load, cnt unchanged, never stalls.
//  FSM IDLE/STALL:
//   - STALL, cmd_ready=1: load slot from the current registers; cnt+1; ip_do_rdy<=1; ->IDLE.
//   - STALL, stall count reaches STALL_MAX: drop the command, err<=1, ip_do_rdy<=1, ->IDLE.
//   - STALL: further ip_wr/ip_rd pulses are ignored (host is blocked by Wait).
//  Slot: cmd_valid falls on cmd_valid&&cmd_ready unless reloaded the same edge. cmd_* stable while cmd_valid=1.
//  Register writes after a CMD never disturb an already-loaded slot.
//  Async reset mid-STALL or mid-handshake: return to reset state; a pending command is lost.
// STRUCTURE
//  Shared package gpu_pkg holds:
//   - register offsets (REG_X1L..REG_SCRATCH)
//   - opcode constants (OP_NOP, OP_PIXEL, OP_LINE, OP_RECT, OP_FILL)
//   - STATUS bit indices
//  Sub-module gpu_cmd_slot holds the one-deep valid/ready slot: load, drain, full.
//  Address decode, register bank, FSM and counters stay in gpu_cmd_ctrl.
// TESTING
//  1. Write X1=0x123 (lo 0x23, hi 0x01), Y2 hi 0xFF -> read back X1hi=0x01, Y2hi=0x01.
//     Write addr 0x05 (outside window) -> read 0x00.
//  2. Load X1=5,Y1=7,X2=100,Y2=50,COLOR=0x3C; write CMD=0x2 with cmd_ready=0
//     -> next cycle cmd_valid=1, cmd_op=2, cmd_x2=100, cmd_color=0x3C, CNT=1, ip_do_rdy=1 throughout.
//  3. Slot full, COLOR=0x11, write CMD=0x3 -> ip_do_rdy=0. Assert cmd_ready at cycle 20
//     -> slot reloads with op=3, color=0x11; ip_do_rdy=1 the next cycle; CNT=2.
//  4. STALL_MAX=15: slot full, cmd_ready held 0, write CMD -> ip_do_rdy returns to 1 after 15 cycles.
//     STATUS reads 0x05; second STATUS read gives 0x01; CNT unchanged.
//  5. cmd_valid=1 and cmd_ready=1 on the same edge as a CMD write -> no stall, new args loaded, cmd_valid stays 1.
//     Write CMD=0 -> no change.
//  6. Assert rst_n=0 mid-STALL -> ip_do_rdy=1, cmd_valid=0, CNT=0, STATUS=0x00 after release.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command controller: register offsets, opcodes,
// STATUS bit positions and the controller state type.
package gpu_pkg;

    localparam logic [3:0] REG_X1L     = 4'h0;
    localparam logic [3:0] REG_X1H     = 4'h1;
    localparam logic [3:0] REG_Y1L     = 4'h2;
    localparam logic [3:0] REG_Y1H     = 4'h3;
    localparam logic [3:0] REG_X2L     = 4'h4;
    localparam logic [3:0] REG_X2H     = 4'h5;
    localparam logic [3:0] REG_Y2L     = 4'h6;
    localparam logic [3:0] REG_Y2H     = 4'h7;
    localparam logic [3:0] REG_COLOR   = 4'h8;
    localparam logic [3:0] REG_CMD     = 4'h9;
    localparam logic [3:0] REG_STATUS  = 4'hA;
    localparam logic [3:0] REG_CNT     = 4'hB;
    localparam logic [3:0] REG_SCRATCH = 4'hC;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PIXEL = 4'h1;
    localparam logic [3:0] OP_LINE  = 4'h2;
    localparam logic [3:0] OP_RECT  = 4'h3;
    localparam logic [3:0] OP_FILL  = 4'h4;

    localparam int STAT_VALID = 0;
    localparam int STAT_BUSY  = 1;
    localparam int STAT_ERR   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_STALL
    } ctrl_state_t;

endpackage

// File: rtl/gpu_cmd_slot.sv
// One-deep command slot between the register bank and the drawing engine.
// A load always wins over a drain on the same edge, so the slot never empties when refilled.
module gpu_cmd_slot #(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [3:0]        ld_op,
    input  logic [X_BITS-1:0] ld_x1,
    input  logic [Y_BITS-1:0] ld_y1,
    input  logic [X_BITS-1:0] ld_x2,
    input  logic [Y_BITS-1:0] ld_y2,
    input  logic [7:0]        ld_color,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [3:0]        cmd_op,
    output logic [X_BITS-1:0] cmd_x1,
    output logic [Y_BITS-1:0] cmd_y1,
    output logic [X_BITS-1:0] cmd_x2,
    output logic [Y_BITS-1:0] cmd_y2,
    output logic [7:0]        cmd_color,
    output logic              drain
);

    assign drain = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_x1    <= '0;
            cmd_y1    <= '0;
            cmd_x2    <= '0;
            cmd_y2    <= '0;
            cmd_color <= '0;
        end else if (load) begin
            cmd_valid <= 1'b1;
            cmd_op    <= ld_op;
            cmd_x1    <= ld_x1;
            cmd_y1    <= ld_y1;
            cmd_x2    <= ld_x2;
            cmd_y2    <= ld_y2;
            cmd_color <= ld_color;
        end else if (drain) begin
            cmd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gpu_cmd_ctrl.sv
// Host register bank on the EPP ip_* bus that turns CMD writes into engine commands,
// stalling the host while the command slot is occupied.
module gpu_cmd_ctrl
    import gpu_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE = 8'h10,
    parameter int         X_BITS    = 10,
    parameter int         Y_BITS    = 9,
    parameter int         STALL_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ip_addr,
    input  logic [7:0]        ip_do,
    input  logic              ip_wr,
    input  logic              ip_rd,
    output logic [7:0]        ip_di,
    output logic              ip_do_rdy,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [3:0]        cmd_op,
    output logic [X_BITS-1:0] cmd_x1,
    output logic [X_BITS-1:0] cmd_x2,
    output logic [Y_BITS-1:0] cmd_y1,
    output logic [Y_BITS-1:0] cmd_y2,
    output logic [7:0]        cmd_color,
    input  logic              eng_busy
);

    localparam int XH      = X_BITS - 8;
    localparam int YH      = Y_BITS - 8;
    localparam int SC_BITS = $clog2(STALL_MAX + 1);

    ctrl_state_t       state;
    logic [X_BITS-1:0] x1, x2;
    logic [Y_BITS-1:0] y1, y2;
    logic [7:0]        color, scratch, cnt, rd_data;
    logic [3:0]        last_op, pend_op, load_op, off;
    logic [SC_BITS-1:0] stall_cnt;
    logic              err, in_win, wr_acc, rd_acc, cmd_wr, new_cmd;
    logic              load, drain, slot_free, timeout;

    assign in_win    = (ip_addr[7:4] == ADDR_BASE[7:4]);
    assign off       = ip_addr[3:0];
    assign wr_acc    = (state == ST_IDLE) && ip_wr && in_win;
    assign rd_acc    = (state == ST_IDLE) && ip_rd && !ip_wr;
    assign cmd_wr    = wr_acc && (off == REG_CMD);
    assign new_cmd   = cmd_wr && (ip_do[3:0] != OP_NOP);
    assign slot_free = !cmd_valid || drain;
    assign timeout   = (stall_cnt == SC_BITS'(STALL_MAX - 1));

    // A stalled command reuses the live registers: host writes are blocked meanwhile.
    always_comb begin
        load    = 1'b0;
        load_op = pend_op;
        if (state == ST_STALL) begin
            load = cmd_ready;
        end else if (new_cmd && slot_free) begin
            load    = 1'b1;
            load_op = ip_do[3:0];
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_win) begin
            case (off)
                REG_X1L:     rd_data = x1[7:0];
                REG_X1H:     rd_data = 8'(x1[X_BITS-1:8]);
                REG_Y1L:     rd_data = y1[7:0];
                REG_Y1H:     rd_data = 8'(y1[Y_BITS-1:8]);
                REG_X2L:     rd_data = x2[7:0];
                REG_X2H:     rd_data = 8'(x2[X_BITS-1:8]);
                REG_Y2L:     rd_data = y2[7:0];
                REG_Y2H:     rd_data = 8'(y2[Y_BITS-1:8]);
                REG_COLOR:   rd_data = color;
                REG_CMD:     rd_data = {4'b0, last_op};
                REG_STATUS:  rd_data = {5'b0, err, eng_busy, cmd_valid};
                REG_CNT:     rd_data = cnt;
                REG_SCRATCH: rd_data = scratch;
                default:     rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1      <= '0;
            y1      <= '0;
            x2      <= '0;
            y2      <= '0;
            color   <= '0;
            scratch <= '0;
            last_op <= '0;
            cnt     <= '0;
        end else begin
            if (wr_acc) begin
                case (off)
                    REG_X1L:     x1[7:0]        <= ip_do;
                    REG_X1H:     x1[X_BITS-1:8] <= ip_do[XH-1:0];
                    REG_Y1L:     y1[7:0]        <= ip_do;
                    REG_Y1H:     y1[Y_BITS-1:8] <= ip_do[YH-1:0];
                    REG_X2L:     x2[7:0]        <= ip_do;
                    REG_X2H:     x2[X_BITS-1:8] <= ip_do[XH-1:0];
                    REG_Y2L:     y2[7:0]        <= ip_do;
                    REG_Y2H:     y2[Y_BITS-1:8] <= ip_do[YH-1:0];
                    REG_COLOR:   color          <= ip_do;
                    REG_CMD:     last_op        <= ip_do[3:0];
                    REG_SCRATCH: scratch        <= ip_do;
                    default:     ;
                endcase
            end
            if (load)
                cnt <= cnt + 8'd1;
        end
    end

    // Host handshake FSM; a timed-out stall drops the command and flags err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ip_di     <= '0;
            ip_do_rdy <= 1'b1;
            pend_op   <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_acc) begin
                        ip_di <= rd_data;
                        if (in_win && off == REG_STATUS)
                            err <= 1'b0;
                    end
                    if (new_cmd && !slot_free) begin
                        state     <= ST_STALL;
                        ip_do_rdy <= 1'b0;
                        pend_op   <= ip_do[3:0];
                        stall_cnt <= '0;
                    end
                end
                ST_STALL: begin
                    if (cmd_ready) begin
                        state     <= ST_IDLE;
                        ip_do_rdy <= 1'b1;
                    end else if (timeout) begin
                        state     <= ST_IDLE;
                        ip_do_rdy <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    gpu_cmd_slot #(
        .X_BITS(X_BITS),
        .Y_BITS(Y_BITS)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .ld_op     (load_op),
        .ld_x1     (x1),
        .ld_y1     (y1),
        .ld_x2     (x2),
        .ld_y2     (y2),
        .ld_color  (color),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_x2    (cmd_x2),
        .cmd_y2    (cmd_y2),
        .cmd_color (cmd_color),
        .drain     (drain)
    );

endmodule

// File: tb/tb_gpu_cmd_ctrl.sv
// Bench for gpu_cmd_ctrl: directed vector table, stall/reset sequences and random traffic
// compared against a register-level reference model.
module tb_gpu_cmd_ctrl;

    localparam logic [7:0] ADDR_BASE = 8'h10;
    localparam int         X_BITS    = 10;
    localparam int         Y_BITS    = 9;
    localparam int         STALL_MAX = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        ip_addr = '0, ip_do = '0, ip_di;
    logic              ip_wr = 1'b0, ip_rd = 1'b0, ip_do_rdy;
    logic              cmd_valid, cmd_ready = 1'b0, eng_busy = 1'b0;
    logic [3:0]        cmd_op;
    logic [X_BITS-1:0] cmd_x1, cmd_x2;
    logic [Y_BITS-1:0] cmd_y1, cmd_y2;
    logic [7:0]        cmd_color;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpu_cmd_ctrl #(
        .ADDR_BASE(ADDR_BASE),
        .X_BITS   (X_BITS),
        .Y_BITS   (Y_BITS),
        .STALL_MAX(STALL_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ip_addr   (ip_addr),
        .ip_do     (ip_do),
        .ip_wr     (ip_wr),
        .ip_rd     (ip_rd),
        .ip_di     (ip_di),
        .ip_do_rdy (ip_do_rdy),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x1    (cmd_x1),
        .cmd_x2    (cmd_x2),
        .cmd_y1    (cmd_y1),
        .cmd_y2    (cmd_y2),
        .cmd_color (cmd_color),
        .eng_busy  (eng_busy)
    );

    // Reference model: coordinates as whole integers, slot as a six-field record.
    int m_coord[4];
    int m_color, m_scratch, m_last, m_cnt, m_di, m_wait, m_pend;
    bit m_err, m_stall, m_valid, m_rdy;
    int m_slot[6];

    function automatic int coord_bits(input int idx);
        return (idx % 2 == 0) ? X_BITS : Y_BITS;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_coord[i] = 0;
        for (int i = 0; i < 6; i++) m_slot[i] = 0;
        m_color = 0; m_scratch = 0; m_last = 0; m_cnt = 0; m_di = 0;
        m_wait = 0; m_pend = 0; m_err = 0; m_stall = 0; m_valid = 0; m_rdy = 1;
    endtask

    task automatic slot_load(input int op);
        m_slot[0] = op;
        for (int i = 0; i < 4; i++) m_slot[i+1] = m_coord[i];
        m_slot[5] = m_color;
        m_valid = 1;
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic model_step(input int a, input int d, input bit wr, input bit rd,
                              input bit rdy_in, input bit busy);
        bit in_win;
        int off, rv, idx, op;
        in_win = (a / 16) == (int'(ADDR_BASE) / 16);
        off = a % 16;
        idx = off / 2;
        op = d % 16;
        rv = 0;
        if (in_win) begin
            if (off < 8)        rv = (off % 2 == 1) ? (m_coord[idx] / 256) : (m_coord[idx] % 256);
            else if (off == 8)  rv = m_color;
            else if (off == 9)  rv = m_last;
            else if (off == 10) rv = 4 * int'(m_err) + 2 * int'(busy) + int'(m_valid);
            else if (off == 11) rv = m_cnt;
            else if (off == 12) rv = m_scratch;
        end
        if (m_valid && rdy_in) m_valid = 0;
        if (m_stall) begin
            if (rdy_in) begin
                slot_load(m_pend);
                m_stall = 0;
                m_rdy = 1;
            end else begin
                m_wait++;
                if (m_wait == STALL_MAX) begin
                    m_err = 1;
                    m_stall = 0;
                    m_rdy = 1;
                end
            end
        end else if (wr) begin
            if (in_win) begin
                if (off < 8) begin
                    if (off % 2 == 0)
                        m_coord[idx] = (m_coord[idx] / 256) * 256 + d;
                    else
                        m_coord[idx] = m_coord[idx] % 256 + (d % (1 << (coord_bits(idx) - 8))) * 256;
                end else if (off == 8) begin
                    m_color = d;
                end else if (off == 12) begin
                    m_scratch = d;
                end else if (off == 9) begin
                    m_last = op;
                    if (op != 0) begin
                        if (!m_valid) begin
                            slot_load(op);
                        end else begin
                            m_stall = 1;
                            m_wait = 0;
                            m_rdy = 0;
                            m_pend = op;
                        end
                    end
                end
            end
        end else if (rd) begin
            m_di = rv;
            if (in_win && off == 10) m_err = 0;
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [63:0] exp_f;
        exp_f = 64'({4'(m_slot[0]), X_BITS'(m_slot[1]), Y_BITS'(m_slot[2]),
                     X_BITS'(m_slot[3]), Y_BITS'(m_slot[4]), 8'(m_slot[5])});
        check_output({tag, "_ip_di"}, 64'(ip_di), 64'(m_di));
        check_output({tag, "_ip_do_rdy"}, 64'(ip_do_rdy), 64'(m_rdy));
        check_output({tag, "_cmd_valid"}, 64'(cmd_valid), 64'(m_valid));
        check_output({tag, "_cmd_fields"},
                     64'({cmd_op, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color}), exp_f);
    endtask

    // One bus cycle: drive, clock, advance the model, then compare just after the edge.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] d, input logic wr,
                                  input logic rd, input logic rdy, input logic busy,
                                  input string tag);
        ip_addr = a; ip_do = d; ip_wr = wr; ip_rd = rd; cmd_ready = rdy; eng_busy = busy;
        @(posedge clk);
        model_step(int'(a), int'(d), wr, rd, rdy, busy);
        #1;
        compare_model(tag);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input logic rdy);
        apply_stimulus(a, d, 1'b1, 1'b0, rdy, 1'b0, "wr");
    endtask

    task automatic bus_read(input logic [7:0] a);
        apply_stimulus(a, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "rd");
    endtask

    task automatic idle(input logic rdy);
        apply_stimulus(8'h00, 8'h00, 1'b0, 1'b0, rdy, 1'b0, "idle");
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
        logic       rd;
        logic [7:0] exp_di;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[29];

    initial begin
        int n;
        logic [7:0] ra, rd_d;
        logic rw, rr, rrdy, rbusy;

        vecs[0]  = '{8'h10, 8'h23, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{8'h11, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{8'h17, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{8'h11, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[4]  = '{8'h17, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0};
        vecs[5]  = '{8'h10, 8'h00, 1'b0, 1'b1, 8'h23, 1'b0};
        vecs[6]  = '{8'h1C, 8'h5A, 1'b1, 1'b0, 8'h23, 1'b0};
        vecs[7]  = '{8'h1C, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0};
        vecs[8]  = '{8'h0C, 8'hFF, 1'b1, 1'b0, 8'h5A, 1'b0};
        vecs[9]  = '{8'h1C, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0};
        vecs[10] = '{8'h05, 8'hAA, 1'b1, 1'b0, 8'h5A, 1'b0};
        vecs[11] = '{8'h05, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[12] = '{8'h1C, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0};
        vecs[13] = '{8'h1F, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[14] = '{8'h10, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{8'h11, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[16] = '{8'h12, 8'h07, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[17] = '{8'h13, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[18] = '{8'h14, 8'h64, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[19] = '{8'h15, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[20] = '{8'h16, 8'h32, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[21] = '{8'h17, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[22] = '{8'h18, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[23] = '{8'h19, 8'h02, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[24] = '{8'h1B, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1};
        vecs[25] = '{8'h19, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1};
        vecs[26] = '{8'h1A, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1};
        vecs[27] = '{8'h1C, 8'h77, 1'b1, 1'b1, 8'h01, 1'b1};
        vecs[28] = '{8'h1C, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_output("reset_ip_di", 64'(ip_di), 64'h00);
        check_output("reset_ip_do_rdy", 64'(ip_do_rdy), 64'h1);
        check_output("reset_cmd_valid", 64'(cmd_valid), 64'h0);
        check_output("reset_cmd_op", 64'(cmd_op), 64'h0);

        // Register access and first command from the vector table.
        for (int i = 0; i < 29; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].rd, 1'b0, 1'b0,
                           $sformatf("vec%0d", i));
            check_output($sformatf("vec%0d_di", i), 64'(ip_di), 64'(vecs[i].exp_di));
            check_output($sformatf("vec%0d_rdy", i), 64'(ip_do_rdy), 64'h1);
            check_output($sformatf("vec%0d_valid", i), 64'(cmd_valid), 64'(vecs[i].exp_valid));
        end
        check_output("t2_cmd_op", 64'(cmd_op), 64'h2);
        check_output("t2_cmd_x1", 64'(cmd_x1), 64'd5);
        check_output("t2_cmd_x2", 64'(cmd_x2), 64'd100);
        check_output("t2_cmd_color", 64'(cmd_color), 64'h3C);

        // Stall on a full slot, ignored write while stalled, release by cmd_ready.
        bus_write(8'h18, 8'h11, 1'b0);
        bus_write(8'h19, 8'h03, 1'b0);
        check_output("t3_stall_rdy", 64'(ip_do_rdy), 64'h0);
        for (int i = 1; i <= 11; i++) begin
            if (i == 5) bus_write(8'h18, 8'h99, 1'b0);
            else idle(1'b0);
        end
        check_output("t3_hold_rdy", 64'(ip_do_rdy), 64'h0);
        check_output("t3_hold_color", 64'(cmd_color), 64'h3C);
        idle(1'b1);
        check_output("t3_release_rdy", 64'(ip_do_rdy), 64'h1);
        check_output("t3_reload_op", 64'(cmd_op), 64'h3);
        check_output("t3_reload_color", 64'(cmd_color), 64'h11);
        bus_read(8'h1B);
        check_output("t3_cnt", 64'(ip_di), 64'h02);

        // Stall timeout drops the command and sets err, cleared by reading STATUS.
        bus_write(8'h19, 8'h04, 1'b0);
        check_output("t4_stall_rdy", 64'(ip_do_rdy), 64'h0);
        n = 0;
        while (!ip_do_rdy && n < 40) begin
            idle(1'b0);
            n++;
        end
        check_output("t4_stall_cycles", 64'(n), 64'(STALL_MAX));
        bus_read(8'h1A);
        check_output("t4_status_err", 64'(ip_di), 64'h05);
        bus_read(8'h1A);
        check_output("t4_status_clr", 64'(ip_di), 64'h01);
        bus_read(8'h1B);
        check_output("t4_cnt", 64'(ip_di), 64'h02);
        check_output("t4_slot_op", 64'(cmd_op), 64'h3);

        // CMD write on the same edge as a drain, then a NOP.
        bus_write(8'h10, 8'hAB, 1'b0);
        bus_write(8'h11, 8'h02, 1'b0);
        bus_write(8'h19, 8'h01, 1'b1);
        check_output("t5_rdy", 64'(ip_do_rdy), 64'h1);
        check_output("t5_valid", 64'(cmd_valid), 64'h1);
        check_output("t5_op", 64'(cmd_op), 64'h1);
        check_output("t5_x1", 64'(cmd_x1), 64'h2AB);
        bus_write(8'h19, 8'h00, 1'b0);
        check_output("t5_nop_rdy", 64'(ip_do_rdy), 64'h1);
        check_output("t5_nop_op", 64'(cmd_op), 64'h1);
        bus_read(8'h1B);
        check_output("t5_cnt", 64'(ip_di), 64'h03);
        apply_stimulus(8'h1A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "busy");
        check_output("t5_status_busy", 64'(ip_di), 64'h03);

        // Asynchronous reset in the middle of a stall.
        bus_write(8'h19, 8'h05, 1'b0);
        idle(1'b0);
        idle(1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_output("t6_rst_rdy", 64'(ip_do_rdy), 64'h1);
        check_output("t6_rst_valid", 64'(cmd_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(8'h1A);
        check_output("t6_status", 64'(ip_di), 64'h00);
        bus_read(8'h1B);
        check_output("t6_cnt", 64'(ip_di), 64'h00);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ADDR_BASE + 8'($urandom_range(0, 15));
            rd_d = 8'($urandom);
            rw = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 2) == 0);
            if (rw && $urandom_range(0, 1) == 1) begin
                ra = ADDR_BASE + 8'h09;
                rd_d = 8'($urandom_range(0, 5));
            end
            rrdy = ($urandom_range(0, 3) == 0);
            rbusy = 1'($urandom);
            apply_stimulus(ra, rd_d, rw, rr, rrdy, rbusy, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
